// File: rtl/host_trace_pkg.sv
// host_trace_pkg: shared state encoding and trace record layout
package host_trace_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;
    localparam int DATA_OFF = 0;
    function automatic int rec_w(input int ts_w, input int data_w);
        return ts_w + 1 + data_w;
    endfunction
    function automatic int valid_off(input int data_w);
        return data_w;
    endfunction
    function automatic int ts_off(input int data_w);
        return data_w + 1;
    endfunction
endpackage

// File: rtl/host_trace_ram.sv
// host_trace_ram: simple dual-port trace buffer with a registered read port
module host_trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 49
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    // write port and one-cycle registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/host_trace_capture.sv
// host_trace_capture: pre/post-trigger capture of host config traffic with an oldest-first drain
module host_trace_capture
    import host_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int TS_W      = 16,
    parameter int POST_TRIG = 32,
    parameter int REC_ALL   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_config_valid,
    input  logic [DATA_W-1:0]        in_config_data,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     abort,
    output logic                     rd_valid,
    output logic [TS_W+DATA_W:0]     rd_data,
    input  logic                     rd_ready,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   rd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = rec_w(TS_W, DATA_W);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PT   = (AW+1)'(POST_TRIG);

    state_t          st, st_n;
    logic [TS_W-1:0] ts;
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_nx;
    logic [AW:0]     cnt, cnt_nx, iss_left, post_cnt;
    logic            qual, in_post, post_hit, consume, issue;
    logic            pend, out_v, skid_v;
    logic [1:0]      occ;
    logic [RW-1:0]   out_d, skid_d, ram_q;

    assign qual     = (st == ST_ARMED || st == ST_POST) && (in_config_valid || REC_ALL != 0);
    assign in_post  = st == ST_POST || (st == ST_ARMED && trig);
    assign post_hit = in_post && qual && (post_cnt + 1'b1 == PT);
    assign wr_nx    = wr_ptr + AW'(qual);
    assign cnt_nx   = cnt + (AW+1)'(qual && cnt != FULL);
    assign consume  = out_v && rd_ready;
    assign occ      = 2'(out_v) + 2'(skid_v) + 2'(pend);
    assign issue    = st == ST_DRAIN && !abort && iss_left != '0 && (occ - 2'(consume)) < 2'd2;
    assign rd_valid = out_v;
    assign rd_data  = out_d;
    assign rd_count = cnt;
    assign state    = st;

    host_trace_ram #(.DEPTH(DEPTH), .W(RW)) u_ram (
        .clk   (clk),
        .we    (qual),
        .waddr (wr_ptr),
        .wdata ({ts, in_config_valid, in_config_data}),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // free-running timestamp stamped into every record
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ts <= '0;
        else ts <= ts + 1'b1;

    // next-state: abort wins, capture ends on the POST_TRIG-th post-trigger entry
    always_comb begin
        st_n = st;
        if (abort) st_n = ST_IDLE;
        else
            case (st)
                ST_IDLE:  st_n = arm ? ST_ARMED : ST_IDLE;
                ST_ARMED: st_n = trig ? (post_hit ? ST_DRAIN : ST_POST) : ST_ARMED;
                ST_POST:  st_n = post_hit ? ST_DRAIN : ST_POST;
                ST_DRAIN: st_n = (consume && cnt == (AW+1)'(1)) ? ST_IDLE : ST_DRAIN;
            endcase
    end

    // state, write pointer, entry count and drain read sequencing
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            st       <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            iss_left <= '0;
            post_cnt <= '0;
        end else begin
            st <= st_n;
            if (abort) begin
                cnt      <= '0;
                iss_left <= '0;
            end else if (st == ST_IDLE) begin
                if (arm) begin
                    wr_ptr   <= '0;
                    cnt      <= '0;
                    post_cnt <= '0;
                end
            end else if (st != ST_DRAIN) begin
                wr_ptr <= wr_nx;
                cnt    <= cnt_nx;
                if (in_post && qual) post_cnt <= post_cnt + 1'b1;
                if (st_n == ST_DRAIN) begin
                    rd_ptr   <= (cnt_nx == FULL) ? wr_nx : '0;
                    iss_left <= cnt_nx;
                end
            end else begin
                if (issue) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    iss_left <= iss_left - 1'b1;
                end
                if (consume) cnt <= cnt - 1'b1;
            end
        end

    // output register plus skid entry absorbing the RAM read latency
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pend   <= 1'b0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_d  <= '0;
            skid_d <= '0;
        end else if (abort) begin
            pend   <= 1'b0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            pend <= issue;
            if (!out_v || consume) begin
                out_v  <= skid_v || pend;
                skid_v <= skid_v && pend;
                if (skid_v || pend) out_d <= skid_v ? skid_d : ram_q;
                if (skid_v && pend) skid_d <= ram_q;
            end else if (pend) begin
                skid_v <= 1'b1;
                skid_d <= ram_q;
            end
        end
endmodule
